// File: rtl/mem_io_bridge_pkg.sv
// Shared MMIO register map, STATUS bit positions and the address-select decode used by mem_io_bridge.
// The CPU bench imports this package so both sides agree on the register layout.
package mem_io_bridge_pkg;

  // Register offsets from MMIO_BASE
  localparam int unsigned MMIO_GPIO   = 0;
  localparam int unsigned MMIO_TXDATA = 1;
  localparam int unsigned MMIO_STATUS = 2;
  localparam int unsigned MMIO_TIMER  = 3;
  localparam int unsigned MMIO_NREGS  = 4;

  // STATUS register bit positions
  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_GPIO,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_TIMER,
    SEL_NONE
  } sel_e;

  function automatic sel_e decode_sel(input logic is_mmio, input logic in_map, input logic [1:0] off);
    sel_e sel;
    sel = SEL_NONE;
    if (!is_mmio) begin
      sel = SEL_RAM;
    end else if (in_map) begin
      case (off)
        2'(MMIO_GPIO):   sel = SEL_GPIO;
        2'(MMIO_TXDATA): sel = SEL_TXDATA;
        2'(MMIO_STATUS): sel = SEL_STATUS;
        2'(MMIO_TIMER):  sel = SEL_TIMER;
        default:         sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// tx_fifo: circular byte FIFO with full/empty/count and a registered head (0 when empty).
// Latency: a push is visible at the head one cycle later. Backpressure: push while full is refused unless a pop happens the same cycle.
module tx_fifo
  import mem_io_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count hides stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU MAR into RAM or MMIO (GPIO, TX FIFO, STATUS, optional TIMER under MMIO_TIMER_EN).
// Latency: reads are combinational from cpu_mar; writes take effect on the next edge. Backpressure: TX pushes into a full FIFO are dropped and flag ovf.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int                   BITS_DATA = 32,
  parameter int                   BITS_ADDR = 16,
  parameter int                   TX_DEPTH  = 4,
  parameter logic [BITS_ADDR-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS_ADDR-1:0] cpu_mar,
  input  logic [BITS_DATA-1:0] cpu_mbr_w,
  input  logic                 cpu_write,
  output logic [BITS_DATA-1:0] cpu_mbr_r,
  output logic [BITS_ADDR-1:0] ram_addr,
  output logic [BITS_DATA-1:0] ram_din,
  output logic                 ram_we,
  input  logic [BITS_DATA-1:0] ram_dout,
  output logic [BITS_DATA-1:0] gpio_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic                 write_q, write_d;
  logic [BITS_ADDR-1:0] mar_q, mar_d;
  logic [BITS_DATA-1:0] gpio_q, gpio_d;
  logic                 ovf_q, ovf_d;

  logic                 wr_stb;
  logic                 is_mmio;
  logic                 in_map;
  logic [BITS_ADDR-1:0] off;
  sel_e                 sel;
  logic [BITS_DATA-1:0] timer_rd;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  // A held write level is one event; moving the address under it starts another.
  assign wr_stb  = cpu_write & (~write_q | (cpu_mar != mar_q));
  assign is_mmio = (cpu_mar >= MMIO_BASE);
  assign off     = cpu_mar - MMIO_BASE;
  assign in_map  = (off < BITS_ADDR'(MMIO_NREGS));
  assign sel     = decode_sel(is_mmio, in_map, off[1:0]);

  assign ram_addr = cpu_mar;
  assign ram_din  = cpu_mbr_w;
  assign ram_we   = wr_stb & (sel == SEL_RAM) & ~reset;
  assign gpio_out = gpio_q;

  assign fifo_push = wr_stb & (sel == SEL_TXDATA);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cpu_mbr_w[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (tx_data)
  );

  always_comb begin
    write_d = cpu_write;
    mar_d   = cpu_mar;
    gpio_d  = gpio_q;
    if (wr_stb && sel == SEL_GPIO) begin
      gpio_d = cpu_mbr_w;
    end
    // A dropped push wins over a STATUS write clearing ovf.
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_stb && sel == SEL_STATUS) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      mar_q   <= '0;
      gpio_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      mar_q   <= mar_d;
      gpio_q  <= gpio_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [BITS_DATA-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (wr_stb && sel == SEL_TIMER) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    cpu_mbr_r = '0;
    case (sel)
      SEL_RAM:    cpu_mbr_r = ram_dout;
      SEL_GPIO:   cpu_mbr_r = gpio_q;
      SEL_TXDATA: cpu_mbr_r[CW-1:0] = fifo_count;
      SEL_STATUS: begin
        cpu_mbr_r[STAT_FULL]           = fifo_full;
        cpu_mbr_r[STAT_EMPTY]          = fifo_empty;
        cpu_mbr_r[STAT_OVF]            = ovf_q;
        cpu_mbr_r[STAT_CNT_LSB +: CW]  = fifo_count;
      end
      SEL_TIMER:  cpu_mbr_r = timer_rd;
      default:    cpu_mbr_r = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios plus a randomized run against a queue-based reference model.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_mar;
  logic [31:0] cpu_mbr_w;
  logic        cpu_write;
  logic [31:0] cpu_mbr_r;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  mem_io_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_mar   (cpu_mar),
    .cpu_mbr_w (cpu_mbr_w),
    .cpu_write (cpu_write),
    .cpu_mbr_r (cpu_mbr_r),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .gpio_out  (gpio_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // Async-read RAM attached to the bridge; unwritten words stay X in both RAM and model.
  logic [31:0] ram_mem [1024];
  assign ram_dout = ram_mem[ram_addr[9:0]];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr[9:0]] <= ram_din;

  localparam logic [15:0] BASE = 16'hFF00;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic [31:0] m_gpio;
  logic [31:0] m_timer;
  logic        m_wq;
  logic [15:0] m_marq;
  logic [31:0] m_ram [1024];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic m_event();
    return cpu_write && (!m_wq || cpu_mar != m_marq);
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] s;
    s = 32'h0;
    if (a < BASE) return m_ram[a[9:0]];
    case (a - BASE)
      16'd0: s = m_gpio;
      16'd1: s = 32'(m_q.size());
      16'd2: begin
        s[0]    = (m_q.size() == 4);
        s[1]    = (m_q.size() == 0);
        s[2]    = m_ovf;
        s[15:8] = 8'(m_q.size());
      end
`ifdef MMIO_TIMER_EN
      16'd3: s = m_timer;
`endif
      default: s = 32'h0;
    endcase
    return s;
  endfunction

  // Applies one clock edge worth of effects to the model, from the inputs now driven.
  task automatic m_advance();
    logic        ev, pop, push, mm;
    logic [15:0] off;
    if (reset) begin
      m_q.delete();
      m_ovf = 0; m_gpio = 0; m_timer = 0; m_wq = 0; m_marq = 0;
      return;
    end
    ev   = m_event();
    mm   = (cpu_mar >= BASE);
    off  = cpu_mar - BASE;
    pop  = (m_q.size() != 0) && tx_ready;
    push = ev && mm && off == 16'd1;
    if (push && m_q.size() == 4 && !pop) m_ovf = 1;
    else if (ev && mm && off == 16'd2) m_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < 4) m_q.push_back(cpu_mbr_w[7:0]);
    if (ev && !mm) m_ram[cpu_mar[9:0]] = cpu_mbr_w;
    if (ev && mm && off == 16'd0) m_gpio = cpu_mbr_w;
    if (ev && mm && off == 16'd3) m_timer = 0;
    else m_timer = m_timer + 1;
    m_wq   = cpu_write;
    m_marq = cpu_mar;
  endtask

  task automatic step();
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cpu_mar = 16'hFF01; cpu_mbr_w = {24'h0, b}; cpu_write = 1;
    @(negedge clk); step();
    cpu_write = 0;
    @(negedge clk); step();
  endtask

  task automatic test_reset();
    reset = 1; cpu_write = 1; cpu_mar = 16'h0005; cpu_mbr_w = 32'hAAAA5555; tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      step();
    end
    reset = 0; cpu_write = 0; cpu_mar = 16'hFF02;
    @(negedge clk);
    n_cmp++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL reset_gpio: got %h want 0", gpio_out); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (cpu_mbr_r !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h want 00000002", cpu_mbr_r); end
    step();
  endtask

  task automatic test_ram_write();
    int we_cnt;
    we_cnt = 0;
    cpu_mar = 16'h0010; cpu_mbr_w = 32'hDEADBEEF; cpu_write = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1) we_cnt++;
      n_cmp++; if (ram_we !== (i == 0)) begin n_err++; $display("FAIL held_write_we[%0d]: got %b want %b", i, ram_we, (i == 0)); end
      step();
    end
    cpu_write = 0;
    @(negedge clk);
    n_cmp++; if (we_cnt != 1) begin n_err++; $display("FAIL held_write_count: got %0d want 1", we_cnt); end
    n_cmp++; if (ram_mem[16] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ram_0x10: got %h want deadbeef", ram_mem[16]); end
    n_cmp++; if (cpu_mbr_r !== 32'hDEADBEEF) begin n_err++; $display("FAIL ram_read_0x10: got %h want deadbeef", cpu_mbr_r); end
    step();
  endtask

  task automatic test_addr_change();
    cpu_write = 1;
    for (int i = 0; i < 3; i++) begin
      cpu_mar = 16'h0020 + 16'(i); cpu_mbr_w = 32'(i + 1);
      @(negedge clk);
      n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL addr_change_we[%0d]: got %b want 1", i, ram_we); end
      step();
    end
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL addr_hold_we: got %b want 0", ram_we); end
    step();
    cpu_write = 0; cpu_mar = 16'h0021;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h2) begin n_err++; $display("FAIL ram_read_0x21: got %h want 00000002", cpu_mbr_r); end
    step();
  endtask

  task automatic test_gpio();
    cpu_mar = 16'hFF00; cpu_mbr_w = 32'h12345678; cpu_write = 1;
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL gpio_ram_we: got %b want 0", ram_we); end
    step();
    cpu_write = 0;
    @(negedge clk);
    n_cmp++; if (gpio_out !== 32'h12345678) begin n_err++; $display("FAIL gpio_out: got %h want 12345678", gpio_out); end
    n_cmp++; if (cpu_mbr_r !== 32'h12345678) begin n_err++; $display("FAIL gpio_read: got %h want 12345678", cpu_mbr_r); end
    step();
    cpu_mar = 16'hFF06; cpu_mbr_w = 32'hFFFFFFFF; cpu_write = 1;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", cpu_mbr_r); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL unmapped_ram_we: got %b want 0", ram_we); end
    step();
    cpu_write = 0;
    @(negedge clk);
    n_cmp++; if (gpio_out !== 32'h12345678) begin n_err++; $display("FAIL unmapped_write_gpio: got %h want 12345678", gpio_out); end
    step();
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i));
    cpu_mar = 16'hFF02;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h0405) begin n_err++; $display("FAIL ovf_status: got %h want 00000405", cpu_mbr_r); end
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL ovf_head: got %h want 41", tx_data); end
    step();
    cpu_mar = 16'hFF01;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h4) begin n_err++; $display("FAIL txdata_count: got %h want 4", cpu_mbr_r); end
    step();
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        n_err++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      step();
    end
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0 (0x45 must be dropped)", tx_valid); end
    step();
    tx_ready = 0;
    cpu_mar = 16'hFF02; cpu_mbr_w = 32'h0; cpu_write = 1;
    @(negedge clk); step();
    cpu_write = 0;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h2) begin n_err++; $display("FAIL ovf_clear: got %h want 00000002", cpu_mbr_r); end
    step();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4];
    exp_b = '{8'h42, 8'h43, 8'h44, 8'h50};
    tx_ready = 0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i));
    cpu_mar = 16'hFF01; cpu_mbr_w = 32'h50; cpu_write = 1; tx_ready = 1;
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL full_pop_head: got %h want 41", tx_data); end
    step();
    cpu_write = 0; tx_ready = 0; cpu_mar = 16'hFF02;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h0401) begin n_err++; $display("FAIL full_pop_status: got %h want 00000401", cpu_mbr_r); end
    step();
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_err++; $display("FAIL full_pop_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]); end
      step();
    end
    tx_ready = 0;
  endtask

  task automatic test_reset_mid();
    cpu_mar = 16'hFF00; cpu_mbr_w = 32'hCAFEF00D; cpu_write = 1;
    @(negedge clk); step();
    cpu_write = 0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    cpu_mar = 16'hFF02; cpu_mbr_w = 32'h0; cpu_write = 1;
    @(negedge clk); step();
    cpu_write = 0;
    @(negedge clk);
    n_cmp++; if (cpu_mbr_r !== 32'h0401) begin n_err++; $display("FAIL status_write_clears_ovf: got %h want 00000401", cpu_mbr_r); end
    step();
    reset = 1; tx_ready = 1;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL reset_cycle_valid: got %b want 1", tx_valid); end
    step();
    reset = 0; tx_ready = 0;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_tx: got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    n_cmp++; if (cpu_mbr_r !== 32'h2) begin n_err++; $display("FAIL mid_reset_status: got %h want 00000002", cpu_mbr_r); end
    n_cmp++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL mid_reset_gpio: got %h want 0", gpio_out); end
    step();
  endtask

  task automatic test_timer();
    cpu_mar = 16'hFF03; cpu_mbr_w = 32'h1234; cpu_write = 1;
    @(negedge clk); step();
    cpu_write = 0;
    repeat (9) begin @(negedge clk); step(); end
    @(negedge clk);
`ifdef MMIO_TIMER_EN
    n_cmp++; if (cpu_mbr_r !== 32'd9 && cpu_mbr_r !== 32'd10) begin n_err++; $display("FAIL timer_range: got %0d want 9 or 10", cpu_mbr_r); end
`else
    n_cmp++; if (cpu_mbr_r !== 32'd0) begin n_err++; $display("FAIL timer_absent: got %h want 0", cpu_mbr_r); end
`endif
    n_cmp++; if (cpu_mbr_r !== m_read(16'hFF03)) begin n_err++; $display("FAIL timer_model: got %h want %h", cpu_mbr_r, m_read(16'hFF03)); end
    step();
  endtask

  task automatic test_random();
    logic [7:0]  exp_d;
    logic        exp_we;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        cpu_write = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0, 1:    cpu_mar = 16'($urandom_range(0, 15));
          2:       cpu_mar = 16'hFF01;
          default: cpu_mar = BASE + 16'($urandom_range(0, 7));
        endcase
        cpu_mbr_w = $urandom;
      end
      tx_ready = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 79) == 0);
      exp_we   = m_event() && (cpu_mar < BASE) && !reset;
      exp_d    = (m_q.size() != 0) ? m_q[0] : 8'h00;
      @(negedge clk);
      n_cmp++; if (ram_we !== exp_we) begin n_err++; $display("FAIL rnd_ram_we c=%0d: got %b want %b", c, ram_we, exp_we); end
      n_cmp++; if (tx_valid !== (m_q.size() != 0) || tx_data !== exp_d) begin
        n_err++; $display("FAIL rnd_tx c=%0d: got v=%b d=%h want v=%b d=%h", c, tx_valid, tx_data, (m_q.size() != 0), exp_d); end
      n_cmp++; if (gpio_out !== m_gpio) begin n_err++; $display("FAIL rnd_gpio c=%0d: got %h want %h", c, gpio_out, m_gpio); end
      n_cmp++; if (cpu_mbr_r !== m_read(cpu_mar)) begin
        n_err++; $display("FAIL rnd_read c=%0d addr=%h: got %h want %h", c, cpu_mar, cpu_mbr_r, m_read(cpu_mar)); end
      step();
    end
    reset = 0; cpu_write = 0; tx_ready = 0;
    @(negedge clk); step();
  endtask

  initial begin
    reset = 1; cpu_mar = 16'h0; cpu_mbr_w = 32'h0; cpu_write = 0; tx_ready = 0;
    m_q.delete(); m_ovf = 0; m_gpio = 0; m_timer = 0; m_wq = 0; m_marq = 0;
    @(posedge clk); #1;
    test_reset();
    test_ram_write();
    test_addr_change();
    test_gpio();
    test_fifo_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_timer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
